spi_txn_scheduler: RTL and testbench
====================================

# spi_txn_scheduler

Two-port transaction scheduler in front of the SPI master/slave engine. It accepts 16-bit transfer requests from two clients, for example the UART bridge and the multiplier result path. It arbitrates between them round-robin, programs the engine's frequency select and data word, and pulses the engine start strobes. It then waits for engine completion, with a timeout, and returns the received word to the granted client.

## Interface
Parameters:
- TIMEOUT_CYCLES, 4096: WAIT-state cycles before a transaction is aborted.
- SETTLE_CYCLES, 4: idle cycles in GAP between transactions; minimum 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req  in  2  per-client request level; bit i = client i
- req_tx  in  2  client i requests transmit
- req_rx  in  2  client i requests receive
- req_freq0 / req_freq1  in  2 each  requested engine freq_control
- req_wdata0 / req_wdata1  in  16 each  word to transmit
- ack  out  2  one-cycle accept pulse, one-hot
- done  out  2  one-cycle completion pulse, one-hot
- timeout  out  1  high with done when the transaction was aborted
- rdata  out  16  received word; held until the next done
- busy  out  1  high in every state except IDLE
- eng_tx_start  out  1  to engine slave_tx_start
- eng_rx_start  out  1  to engine slave_rx_start
- eng_wdata  out  16  to engine miso_reg_data
- eng_freq  out  2  to engine freq_control
- eng_tx_done  in  1  from engine tx_done
- eng_rx_valid  in  1  from engine rx_valid
- eng_rdata  in  16  from engine mosi_reg_data

## Operation
States are IDLE, LAUNCH, WAIT, DONE and GAP.
- **IDLE**
  - Sample req each cycle.
  - If exactly one bit is set, grant that client.
  - If both bits are set, grant the client not granted last. The last-grant register resets to 1, so client 0 wins the first tie.
  - Latch req_tx, req_rx, req_freqN and req_wdataN of the granted client into working registers.
  - Go to LAUNCH.
- **LAUNCH** (1 cycle)
  - ack[g] = 1.
  - eng_freq and eng_wdata drive the latched values.
  - eng_tx_start = latched tx; eng_rx_start = latched rx.
  - Set pending flags tx_pend = tx and rx_pend = rx.
  - If both tx and rx are 0, go directly to DONE with rdata unchanged and timeout = 0. Otherwise go to WAIT.
- **WAIT**
  - eng_freq and eng_wdata stay stable.
  - Start strobes are 0.
  - Engine status is ignored in the first WAIT cycle, because status from the prior transaction may still be asserted.
  - From the second WAIT cycle on:
    - eng_tx_done high clears tx_pend.
    - eng_rx_valid high clears rx_pend and captures eng_rdata into the rdata holding register.
  - When both flags are clear, go to DONE.
  - The timeout counter increments every WAIT cycle. On reaching TIMEOUT_CYCLES-1 with a flag still set, go to DONE with the abort flag set.
- **DONE** (1 cycle)
  - done[g] = 1.
  - timeout = abort flag.
  - On abort, rdata is forced to 16'h0000.
  - Go to GAP.
- **GAP**
  - Wait SETTLE_CYCLES cycles so cs_bar deasserts and the clock divider settles.
  - Then go to IDLE.
  - req is not sampled in GAP.
- **Request rules**
  - A client holds req until it sees ack. req changes during other states are ignored.
  - A client holding req after ack issues a new request, which is arbitrated in the next IDLE.
- **Reset** (asynchronous, at any time, including mid-WAIT)
  - State goes to IDLE.
  - ack, done, timeout, busy, eng_tx_start and eng_rx_start = 0.
  - rdata and eng_wdata = 16'h0000.
  - eng_freq = 2'b00.
  - Last grant = 1; counters = 0.
  - Any in-flight engine result is discarded.

## Timing
- req seen high in IDLE at edge k: LAUNCH in cycle k+1 (ack and strobes high); WAIT starts at k+2.
- Start strobes are exactly one cycle wide and coincide with ack.
- done asserts the cycle after the last pending flag clears. rdata is valid in that same cycle.
- Minimum spacing between consecutive ack pulses: 4 + SETTLE_CYCLES + completion time.
- eng_freq changes only on entry to LAUNCH, never during WAIT or GAP.
- An abort yields done exactly TIMEOUT_CYCLES cycles after WAIT entry.
- ack, done and timeout are registered outputs.

## Test plan
- **Single TX:** client 0 sends tx=1, rx=0, wdata=16'h55AA, freq=2'b01 with the engine in loopback.
  - ack[0] one cycle, eng_tx_start one cycle, eng_wdata=16'h55AA until done[0].
  - timeout=0; 16'h55AA shifted out MSB first.
- **TX+RX loopback:** client 1 sends wdata=16'h1234, tx=rx=1.
  - done[1] only after both engine completions.
  - rdata=16'h1234, held until the next done.
- **Simultaneous requests:** both clients request from reset.
  - Grant order is 0, then 1, then 0 while both requests stay held.
  - Exactly one ack bit is high per transaction.
- **Timeout:** tie eng_tx_done=0 with TIMEOUT_CYCLES=64.
  - done and timeout assert together 64 cycles after WAIT entry.
  - rdata=16'h0000; the next request is still served.
- **Frequency change:** request freq=2'b11 after a freq=2'b01 transfer.
  - eng_freq changes only in LAUNCH.
  - At least SETTLE_CYCLES idle cycles lie between the two transactions.
- **Reset mid-WAIT:** assert reset during a transfer.
  - All outputs reach reset values immediately; no done pulse is produced.
  - After release, the first request is served normally.

Source files
------------

// File: rtl/spi_txn_scheduler.sv
// Two-client round-robin front end for the SPI engine: launches one transfer at a
// time, waits for engine completion under a timeout and returns the received word.
module spi_txn_scheduler #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int SETTLE_CYCLES  = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  req_i,
    input  logic [1:0]  req_tx_i,
    input  logic [1:0]  req_rx_i,
    input  logic [1:0]  req_freq0_i,
    input  logic [1:0]  req_freq1_i,
    input  logic [15:0] req_wdata0_i,
    input  logic [15:0] req_wdata1_i,
    output logic [1:0]  ack_o,
    output logic [1:0]  done_o,
    output logic        timeout_o,
    output logic [15:0] rdata_o,
    output logic        busy_o,
    output logic        eng_tx_start_o,
    output logic        eng_rx_start_o,
    output logic [15:0] eng_wdata_o,
    output logic [1:0]  eng_freq_o,
    input  logic        eng_tx_done_i,
    input  logic        eng_rx_valid_i,
    input  logic [15:0] eng_rdata_i
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int GW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [TW-1:0] WCNT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GCNT_LAST = GW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DONE,
        S_GAP
    } state_e;

    state_e        state_q;
    logic          last_q;
    logic          gnt_q;
    logic          tx_q;
    logic          rx_q;
    logic          tx_pend_q;
    logic          rx_pend_q;
    logic [TW-1:0] wcnt_q;
    logic [GW-1:0] gcnt_q;
    logic [15:0]   cap_q;
    logic [1:0]    ack_q;
    logic [1:0]    done_q;
    logic          timeout_q;
    logic [15:0]   rdata_q;
    logic          busy_q;
    logic          tx_start_q;
    logic          rx_start_q;
    logic [15:0]   eng_wdata_q;
    logic [1:0]    eng_freq_q;

    logic          gnt_d;
    logic          status_ok;
    logic          rx_hit;
    logic          tx_pend_d;
    logic          rx_pend_d;

    // Engine status is trusted only from the second WAIT cycle: the previous
    // transfer's tx_done/rx_valid may still be high in the first one.
    always_comb begin
        gnt_d     = (req_i == 2'b11) ? ~last_q : req_i[1];
        status_ok = (wcnt_q != '0);
        rx_hit    = rx_pend_q && status_ok && eng_rx_valid_i;
        tx_pend_d = tx_pend_q && !(status_ok && eng_tx_done_i);
        rx_pend_d = rx_pend_q && !rx_hit;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            gnt_q       <= 1'b0;
            tx_q        <= 1'b0;
            rx_q        <= 1'b0;
            tx_pend_q   <= 1'b0;
            rx_pend_q   <= 1'b0;
            wcnt_q      <= '0;
            gcnt_q      <= '0;
            cap_q       <= 16'h0000;
            ack_q       <= 2'b00;
            done_q      <= 2'b00;
            timeout_q   <= 1'b0;
            rdata_q     <= 16'h0000;
            busy_q      <= 1'b0;
            tx_start_q  <= 1'b0;
            rx_start_q  <= 1'b0;
            eng_wdata_q <= 16'h0000;
            eng_freq_q  <= 2'b00;
        end else begin
            ack_q      <= 2'b00;
            done_q     <= 2'b00;
            timeout_q  <= 1'b0;
            tx_start_q <= 1'b0;
            rx_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_i != 2'b00) begin
                        gnt_q       <= gnt_d;
                        last_q      <= gnt_d;
                        tx_q        <= req_tx_i[gnt_d];
                        rx_q        <= req_rx_i[gnt_d];
                        ack_q       <= gnt_d ? 2'b10 : 2'b01;
                        tx_start_q  <= req_tx_i[gnt_d];
                        rx_start_q  <= req_rx_i[gnt_d];
                        eng_freq_q  <= gnt_d ? req_freq1_i : req_freq0_i;
                        eng_wdata_q <= gnt_d ? req_wdata1_i : req_wdata0_i;
                        busy_q      <= 1'b1;
                        state_q     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    tx_pend_q <= tx_q;
                    rx_pend_q <= rx_q;
                    cap_q     <= rdata_q;
                    wcnt_q    <= '0;
                    if (!tx_q && !rx_q) begin
                        done_q  <= gnt_q ? 2'b10 : 2'b01;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    wcnt_q    <= wcnt_q + TW'(1);
                    tx_pend_q <= tx_pend_d;
                    rx_pend_q <= rx_pend_d;
                    if (rx_hit) begin
                        cap_q <= eng_rdata_i;
                    end
                    if (!tx_pend_d && !rx_pend_d) begin
                        done_q  <= gnt_q ? 2'b10 : 2'b01;
                        rdata_q <= rx_hit ? eng_rdata_i : cap_q;
                        state_q <= S_DONE;
                    end else if (wcnt_q == WCNT_LAST) begin
                        done_q    <= gnt_q ? 2'b10 : 2'b01;
                        timeout_q <= 1'b1;
                        rdata_q   <= 16'h0000;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    tx_pend_q <= 1'b0;
                    rx_pend_q <= 1'b0;
                    gcnt_q    <= '0;
                    state_q   <= S_GAP;
                end
                S_GAP: begin
                    if (gcnt_q == GCNT_LAST) begin
                        gcnt_q  <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        gcnt_q <= gcnt_q + GW'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ack_o          = ack_q;
    assign done_o         = done_q;
    assign timeout_o      = timeout_q;
    assign rdata_o        = rdata_q;
    assign busy_o         = busy_q;
    assign eng_tx_start_o = tx_start_q;
    assign eng_rx_start_o = rx_start_q;
    assign eng_wdata_o    = eng_wdata_q;
    assign eng_freq_o     = eng_freq_q;
endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Randomized bench for spi_txn_scheduler: a per-transaction timeline model predicts
// every output cycle by cycle, plus directed scenarios with literal expectations.
module tb_spi_txn_scheduler;
    localparam int TO = 64;
    localparam int ST = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, req_tx, req_rx, req_freq0, req_freq1;
    logic [15:0] req_wdata0, req_wdata1;
    logic [1:0]  ack, done;
    logic        timeout, busy, tx_start, rx_start;
    logic [15:0] rdata, eng_wdata;
    logic [1:0]  eng_freq;
    logic        eng_tx_done, eng_rx_valid;
    logic [15:0] eng_rdata;

    always #5 clk = ~clk;

    spi_txn_scheduler #(.TIMEOUT_CYCLES(TO), .SETTLE_CYCLES(ST)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(req), .req_tx_i(req_tx), .req_rx_i(req_rx),
        .req_freq0_i(req_freq0), .req_freq1_i(req_freq1),
        .req_wdata0_i(req_wdata0), .req_wdata1_i(req_wdata1),
        .ack_o(ack), .done_o(done), .timeout_o(timeout), .rdata_o(rdata),
        .busy_o(busy), .eng_tx_start_o(tx_start), .eng_rx_start_o(rx_start),
        .eng_wdata_o(eng_wdata), .eng_freq_o(eng_freq),
        .eng_tx_done_i(eng_tx_done), .eng_rx_valid_i(eng_rx_valid),
        .eng_rdata_i(eng_rdata)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Timeline model: expected output events keyed by cycle number
    logic [1:0]  e_ack[int];
    logic [1:0]  e_done[int];
    bit          e_to[int];
    bit          e_txs[int];
    bit          e_rxs[int];
    bit          e_busy_chg[int];
    logic [15:0] e_wd_chg[int];
    logic [15:0] e_rd_chg[int];
    logic [1:0]  e_fr_chg[int];
    bit          cur_busy = 1'b0;
    logic [15:0] cur_wd = 16'h0, cur_rd = 16'h0;
    logic [1:0]  cur_fr = 2'b00;
    bit          chk_en = 1'b0;

    int          obs_ack_cyc = 0, obs_done_cyc = 0;
    logic [1:0]  obs_ack_val = 2'b00, obs_done_val = 2'b00, obs_fr_at_ack = 2'b00;
    logic        obs_to = 1'b0;
    logic [15:0] obs_rd = 16'h0, obs_wd = 16'h0;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (ack != 2'b00) begin
                obs_ack_cyc = cyc; obs_ack_val = ack; obs_fr_at_ack = eng_freq;
            end
            if (done != 2'b00) begin
                obs_done_cyc = cyc; obs_done_val = done; obs_to = timeout;
                obs_rd = rdata; obs_wd = eng_wdata;
            end
        end
        if (chk_en && rst_n === 1'b1) begin
            if (e_busy_chg.exists(cyc)) cur_busy = e_busy_chg[cyc];
            if (e_wd_chg.exists(cyc))   cur_wd   = e_wd_chg[cyc];
            if (e_rd_chg.exists(cyc))   cur_rd   = e_rd_chg[cyc];
            if (e_fr_chg.exists(cyc))   cur_fr   = e_fr_chg[cyc];
            chk("ack", 32'(ack), 32'(e_ack.exists(cyc) ? e_ack[cyc] : 2'b00));
            chk("done", 32'(done), 32'(e_done.exists(cyc) ? e_done[cyc] : 2'b00));
            chk("timeout", 32'(timeout), 32'(e_to.exists(cyc) ? e_to[cyc] : 1'b0));
            chk("tx_start", 32'(tx_start), 32'(e_txs.exists(cyc) ? e_txs[cyc] : 1'b0));
            chk("rx_start", 32'(rx_start), 32'(e_rxs.exists(cyc) ? e_rxs[cyc] : 1'b0));
            chk("busy", 32'(busy), 32'(cur_busy));
            chk("eng_wdata", 32'(eng_wdata), 32'(cur_wd));
            chk("eng_freq", 32'(eng_freq), 32'(cur_fr));
            chk("rdata", 32'(rdata), 32'(cur_rd));
        end
    end

    // Client request state and per-transaction engine behaviour
    bit          pend[2];
    bit          p_tx[2], p_rx[2];
    logic [1:0]  p_f[2];
    logic [15:0] p_wd[2];
    bit          m_last = 1'b1;
    logic [15:0] m_rdata = 16'h0;
    int          next_idle = 0;
    int          last_c = 0;
    int          dly_t = 1, dly_r = 1, extra = 0;
    bit          stale = 1'b0, keep_g = 1'b0, late_post = 1'b0;
    logic [15:0] rxword = 16'h0;

    task automatic to_cycle(input int n);
        chk("sched", 32'(cyc > n), 32'd0);
        while (cyc < n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive_req();
        req        = {pend[1], pend[0]};
        req_tx     = {p_tx[1], p_tx[0]};
        req_rx     = {p_rx[1], p_rx[0]};
        req_freq0  = p_f[0];
        req_freq1  = p_f[1];
        req_wdata0 = p_wd[0];
        req_wdata1 = p_wd[1];
    endtask

    task automatic post(input int cl, input bit tx, input bit rx, input logic [1:0] f,
                        input logic [15:0] wd);
        pend[cl] = 1'b1; p_tx[cl] = tx; p_rx[cl] = rx; p_f[cl] = f; p_wd[cl] = wd;
    endtask

    task automatic post_rand(input int cl);
        post(cl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 16'($urandom));
    endtask

    task automatic cfg(input int dt, input int dr, input bit st, input logic [15:0] rw,
                       input bit kg, input bit lp, input int ex);
        dly_t = dt; dly_r = dr; stale = st; rxword = rw; keep_g = kg; late_post = lp; extra = ex;
    endtask

    function automatic int pick_dly();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return $urandom_range(1, 12);
        if (r == 6) return TO - 1;
        if (r == 7) return TO;
        if (r == 8) return 1;
        return 1000;
    endfunction

    task automatic run_txn();
        int c, L, W, D, g, m, j;
        bit tx, rx, ab;
        logic [1:0] mask;
        logic [15:0] nrd;
        c = (req != 2'b00) ? next_idle : next_idle + extra;
        to_cycle(c);
        drive_req();
        last_c = c;
        mask = {pend[1], pend[0]};
        g = (mask == 2'b11) ? (m_last ? 0 : 1) : (mask[1] ? 1 : 0);
        m_last = (g == 1);
        tx = p_tx[g];
        rx = p_rx[g];
        L = c + 1;
        W = c + 2;
        m = 0;
        if (tx && dly_t > m) m = dly_t;
        if (rx && dly_r > m) m = dly_r;
        ab = 1'b0;
        if (!tx && !rx)   D = L + 1;
        else if (m < TO)  D = W + m + 1;
        else begin        D = W + TO; ab = 1'b1; end
        e_ack[L] = (g == 1) ? 2'b10 : 2'b01;
        e_txs[L] = tx;
        e_rxs[L] = rx;
        e_fr_chg[L] = p_f[g];
        e_wd_chg[L] = p_wd[g];
        e_busy_chg[L] = 1'b1;
        e_busy_chg[D + ST + 1] = 1'b0;
        e_done[D] = (g == 1) ? 2'b10 : 2'b01;
        e_to[D] = ab;
        nrd = ab ? 16'h0000 : (rx ? rxword : m_rdata);
        e_rd_chg[D] = nrd;
        m_rdata = nrd;
        next_idle = D + ST + 1;

        to_cycle(L);
        if (keep_g) post_rand(g);
        else pend[g] = 1'b0;
        if (late_post && !pend[1 - g]) post_rand(1 - g);
        drive_req();
        for (int n = W; n <= D; n++) begin
            to_cycle(n);
            if (n == W) begin
                eng_tx_done = stale; eng_rx_valid = stale; eng_rdata = 16'($urandom);
            end else begin
                j = n - W;
                eng_tx_done  = tx && (dly_t == j);
                eng_rx_valid = rx && (dly_r == j);
                eng_rdata    = eng_rx_valid ? rxword : 16'($urandom);
            end
        end
        to_cycle(D + 1);
        eng_tx_done = 1'b0; eng_rx_valid = 1'b0; eng_rdata = 16'h0;
    endtask

    initial begin
        #2_000_000;
        n_cmp++; n_bad++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        logic [1:0] ord[4];
        int d1;
        logic [1:0] f1;
        int c;
        rst_n = 1'b0;
        req = 2'b00; req_tx = 2'b00; req_rx = 2'b00; req_freq0 = 2'b00; req_freq1 = 2'b00;
        req_wdata0 = 16'h0; req_wdata1 = 16'h0;
        eng_tx_done = 1'b0; eng_rx_valid = 1'b0; eng_rdata = 16'h0;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; p_tx[i] = 1'b0; p_rx[i] = 1'b0; p_f[i] = 2'b00; p_wd[i] = 16'h0;
        end
        @(posedge clk);
        #2;
        chk("reset_ack", 32'(ack), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rdata", 32'(rdata), 32'd0);
        chk("reset_wdata", 32'(eng_wdata), 32'd0);
        to_cycle(3);
        rst_n = 1'b1;
        next_idle = cyc + 1;
        chk_en = 1'b1;

        // Single TX, client 0
        post(0, 1'b1, 1'b0, 2'b01, 16'h55AA);
        cfg(3, 1, 1'b0, 16'h0, 1'b0, 1'b0, 0);
        run_txn();
        chk("single_ack_val", 32'(obs_ack_val), 32'h1);
        chk("single_ack_lat", obs_ack_cyc - last_c, 1);
        chk("single_done_lat", obs_done_cyc - obs_ack_cyc, 5);
        chk("single_wdata", 32'(obs_wd), 32'h55AA);
        chk("single_to", 32'(obs_to), 32'h0);

        // TX+RX, client 1
        post(1, 1'b1, 1'b1, 2'b10, 16'h1234);
        cfg(2, 5, 1'b1, 16'h1234, 1'b0, 1'b0, 1);
        run_txn();
        chk("txrx_done_val", 32'(obs_done_val), 32'h2);
        chk("txrx_done_lat", obs_done_cyc - obs_ack_cyc, 7);
        chk("txrx_rdata", 32'(obs_rd), 32'h1234);

        // Both clients held: 0, 1, 0, then drain 1
        post_rand(0);
        post_rand(1);
        for (int i = 0; i < 4; i++) begin
            cfg($urandom_range(1, 6), $urandom_range(1, 6), 1'b1, 16'($urandom),
                (i < 2), 1'b0, 0);
            run_txn();
            ord[i] = obs_ack_val;
        end
        chk("tie_0", 32'(ord[0]), 32'h1);
        chk("tie_1", 32'(ord[1]), 32'h2);
        chk("tie_2", 32'(ord[2]), 32'h1);
        chk("tie_3", 32'(ord[3]), 32'h2);

        // Timeout, then normal service
        post(0, 1'b1, 1'b0, 2'b01, 16'h0F0F);
        cfg(1000, 1, 1'b0, 16'h0, 1'b0, 1'b0, 0);
        run_txn();
        chk("to_flag", 32'(obs_to), 32'h1);
        chk("to_latency", obs_done_cyc - (obs_ack_cyc + 1), TO);
        chk("to_rdata", 32'(obs_rd), 32'h0);
        post(1, 1'b0, 1'b1, 2'b00, 16'hA5A5);
        cfg(1, 4, 1'b1, 16'hC3E1, 1'b0, 1'b0, 0);
        run_txn();
        chk("after_to_done", 32'(obs_done_val), 32'h2);
        chk("after_to_rdata", 32'(obs_rd), 32'hC3E1);

        // Frequency change between back-to-back transfers
        post(0, 1'b1, 1'b0, 2'b01, 16'h1111);
        cfg(2, 1, 1'b0, 16'h0, 1'b0, 1'b0, 0);
        run_txn();
        d1 = obs_done_cyc;
        f1 = obs_fr_at_ack;
        post(0, 1'b1, 1'b0, 2'b11, 16'h2222);
        cfg(2, 1, 1'b0, 16'h0, 1'b0, 1'b0, 2);
        run_txn();
        chk("freq_first", 32'(f1), 32'h1);
        chk("freq_second", 32'(obs_fr_at_ack), 32'h3);
        chk("freq_gap", 32'((obs_ack_cyc - d1 - 1) >= ST), 32'h1);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            if (!pend[0] && !pend[1]) begin
                int r;
                r = $urandom_range(1, 3);
                if (r[0]) post_rand(0);
                if (r[1]) post_rand(1);
            end else if ($urandom_range(0, 3) == 0) begin
                if (!pend[0]) post_rand(0);
                if (!pend[1]) post_rand(1);
            end
            cfg(pick_dly(), pick_dly(), 1'($urandom_range(0, 1)), 16'($urandom),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                $urandom_range(0, 3));
            run_txn();
        end
        while (pend[0] || pend[1]) begin
            cfg(2, 3, 1'b0, 16'($urandom), 1'b0, 1'b0, 0);
            run_txn();
        end

        // Reset in the middle of WAIT
        chk_en = 1'b0;
        c = next_idle;
        to_cycle(c);
        post(0, 1'b1, 1'b1, 2'b10, 16'hBEEF);
        drive_req();
        to_cycle(c + 1);
        chk("rst_ack", 32'(ack), 32'h1);
        pend[0] = 1'b0;
        drive_req();
        to_cycle(c + 6);
        chk("rst_busy_before", 32'(busy), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_ack0", 32'(ack), 32'h0);
        chk("rst_done0", 32'(done), 32'h0);
        chk("rst_to0", 32'(timeout), 32'h0);
        chk("rst_busy0", 32'(busy), 32'h0);
        chk("rst_txs0", 32'(tx_start), 32'h0);
        chk("rst_rxs0", 32'(rx_start), 32'h0);
        chk("rst_rdata0", 32'(rdata), 32'h0);
        chk("rst_wdata0", 32'(eng_wdata), 32'h0);
        chk("rst_freq0", 32'(eng_freq), 32'h0);
        eng_tx_done = 1'b1; eng_rx_valid = 1'b1; eng_rdata = 16'hBEEF;
        to_cycle(c + 8);
        rst_n = 1'b1;
        for (int n = c + 9; n <= c + 12; n++) begin
            to_cycle(n);
            eng_tx_done = 1'b0; eng_rx_valid = 1'b0; eng_rdata = 16'h0;
            chk("rst_no_done", 32'(done), 32'h0);
            chk("rst_rdata_hold", 32'(rdata), 32'h0);
        end
        e_ack.delete(); e_done.delete(); e_to.delete(); e_txs.delete(); e_rxs.delete();
        e_busy_chg.delete(); e_wd_chg.delete(); e_rd_chg.delete(); e_fr_chg.delete();
        m_last = 1'b1; m_rdata = 16'h0;
        cur_busy = 1'b0; cur_wd = 16'h0; cur_rd = 16'h0; cur_fr = 2'b00;
        next_idle = cyc + 1;
        chk_en = 1'b1;
        post_rand(0);
        post(1, 1'b1, 1'b1, 2'b01, 16'h7E57);
        cfg(3, 4, 1'b0, 16'h5A5A, 1'b0, 1'b0, 0);
        run_txn();
        chk("post_rst_tie", 32'(obs_ack_val), 32'h1);
        cfg(3, 4, 1'b1, 16'h5A5A, 1'b0, 1'b0, 0);
        run_txn();
        chk("post_rst_rdata", 32'(obs_rd), 32'h5A5A);

        to_cycle(next_idle + 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
